// File: rtl/soric_bank_arbiter_pkg.sv
// Shared constants for the SRAM bank arbiter: OBI data/byte-enable widths and
// the byte-to-word address width helper for the sky130 macro.
package soric_pkg;
   localparam int OBI_DW  = 32;
   localparam int OBI_BEW = 4;

   // The macro is word addressed, so the two byte-offset bits drop out.
   function automatic int sram_word_aw(input int addr_w);
      return addr_w - 2;
   endfunction
endpackage

// File: rtl/soric_bank_arbiter_if.sv
// Bundle of the master-side OBI signals and the macro-side SRAM pins for one bank.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface soric_bank_arbiter_if
   import soric_pkg::*;
#(
   parameter int NMASTER     = 2,
   parameter int SRAM_ADDR_W = 11
) ();
   logic [NMASTER-1:0]             m_req_i;
   logic [NMASTER-1:0]             m_we_i;
   logic [NMASTER*OBI_BEW-1:0]     m_be_i;
   logic [NMASTER*SRAM_ADDR_W-1:0] m_addr_i;
   logic [NMASTER*OBI_DW-1:0]      m_wdata_i;
   logic [NMASTER-1:0]             m_gnt_o;
   logic [NMASTER-1:0]             m_rvalid_o;
   logic [OBI_DW-1:0]              m_rdata_o;
   logic                           s_csb_o;
   logic                           s_web_o;
   logic [OBI_BEW-1:0]             s_wmask_o;
   logic [SRAM_ADDR_W-3:0]         s_addr_o;
   logic [OBI_DW-1:0]              s_din_o;
   logic [OBI_DW-1:0]              s_dout_i;

   modport slave (
      input  m_req_i, m_we_i, m_be_i, m_addr_i, m_wdata_i, s_dout_i,
      output m_gnt_o, m_rvalid_o, m_rdata_o,
      output s_csb_o, s_web_o, s_wmask_o, s_addr_o, s_din_o
   );

   modport master (
      output m_req_i, m_we_i, m_be_i, m_addr_i, m_wdata_i, s_dout_i,
      input  m_gnt_o, m_rvalid_o, m_rdata_o,
      input  s_csb_o, s_web_o, s_wmask_o, s_addr_o, s_din_o
   );
endinterface

// File: rtl/soric_bank_arbiter_rr.sv
// Round-robin arbiter: search starts one past the last winner, so the previous
// winner has lowest priority. The pointer only moves on a granted cycle.
module soric_rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          advance_i,
   input  logic [N-1:0]  req_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);
   logic [IW-1:0] r_ptr;

   always_comb begin : arb_search
      int j;
      j     = 0;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int k = 1; k <= N; k++) begin
         j = int'(r_ptr) + k;
         if (j >= N) j = j - N;
         if (!any_o && req_i[j]) begin
            any_o    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IW'(j);
         end
      end
   end

   // Reset pointer to the last master so master 0 wins the first contest.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         r_ptr <= IW'(N - 1);
      else if (advance_i && any_o)
         r_ptr <= idx_o;
   end
endmodule

// File: rtl/soric_bank_arbiter.sv
// One-bank SRAM port arbiter: round-robin grant, winner muxed onto the macro pins,
// one-cycle response stage, and a saturating counter of contended cycles.
module soric_bank_arbiter
   import soric_pkg::*;
#(
   parameter int NMASTER     = 2,
   parameter int SRAM_ADDR_W = 11,
   parameter int CNT_W       = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   soric_bank_arbiter_if.slave bus,
   input  logic               cnt_clr_i,
   output logic [CNT_W-1:0]   conflict_cnt_o
);
   localparam int IW  = $clog2(NMASTER);
   localparam int WAW = sram_word_aw(SRAM_ADDR_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NMASTER-1:0] w_gnt;
   logic [IW-1:0]      w_idx;
   logic               w_any;
   logic               w_conflict;
   logic               w_unused_addr;

   logic               r_rsp_valid;
   logic [IW-1:0]      r_rsp_idx;
   logic               r_rsp_we;
   logic [CNT_W-1:0]   r_cnt;

   soric_rr_arbiter #(.N(NMASTER), .IW(IW)) u_rr (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .advance_i (w_any),
      .req_i     (bus.m_req_i),
      .gnt_o     (w_gnt),
      .idx_o     (w_idx),
      .any_o     (w_any)
   );

   assign bus.m_gnt_o = w_gnt;
   // Byte-offset bits are architecturally ignored.
   assign w_unused_addr = ^bus.m_addr_i;

   always_comb begin
      bus.s_csb_o   = 1'b1;
      bus.s_web_o   = 1'b1;
      bus.s_wmask_o = '0;
      bus.s_addr_o  = '0;
      bus.s_din_o   = '0;
      if (w_any) begin
         bus.s_csb_o   = 1'b0;
         bus.s_web_o   = ~bus.m_we_i[w_idx];
         bus.s_wmask_o = bus.m_be_i[w_idx*OBI_BEW +: OBI_BEW];
         bus.s_addr_o  = bus.m_addr_i[w_idx*SRAM_ADDR_W + 2 +: WAW];
         bus.s_din_o   = bus.m_wdata_i[w_idx*OBI_DW +: OBI_DW];
      end
   end

   // Writes also get an rvalid; the response stage never stalls.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rsp_valid <= 1'b0;
         r_rsp_idx   <= '0;
         r_rsp_we    <= 1'b0;
      end else begin
         r_rsp_valid <= w_any;
         r_rsp_idx   <= w_idx;
         r_rsp_we    <= bus.m_we_i[w_idx];
      end
   end

   for (genvar gi = 0; gi < NMASTER; gi++) begin : g_rvalid
      assign bus.m_rvalid_o[gi] = r_rsp_valid && (r_rsp_idx == IW'(gi));
   end

   assign bus.m_rdata_o = (r_rsp_valid && !r_rsp_we) ? bus.s_dout_i : '0;

   assign w_conflict = ($countones(bus.m_req_i) >= 2);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         r_cnt <= '0;
      else if (cnt_clr_i)
         r_cnt <= '0;
      else if (w_conflict && (r_cnt != CNT_MAX))
         r_cnt <= r_cnt + 1'b1;
   end

   assign conflict_cnt_o = r_cnt;
endmodule

// File: tb/tb_soric_bank_arbiter.sv
// Randomised scoreboard bench for soric_bank_arbiter: a behavioural model predicts
// grants, macro pins and responses; a separate monitor checks responses as they appear.
module tb_soric_bank_arbiter;
   localparam int N  = 2;
   localparam int AW = 11;
   localparam int CW = 3;

   typedef struct {
      int          idx;
      logic [31:0] data;
      int          cyc;
   } rsp_t;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          cnt_clr = 1'b0;
   logic [CW-1:0] cnt;

   int            n_vec = 0;
   int            n_err = 0;
   int            cyc = 0;

   logic [31:0]   macro_mem [512] = '{default: 32'h0};
   logic [31:0]   exp_mem   [512] = '{default: 32'h0};
   int            m_last = N - 1;
   int            m_cnt = 0;
   rsp_t          q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   soric_bank_arbiter_if #(.NMASTER(N), .SRAM_ADDR_W(AW)) bus ();

   soric_bank_arbiter #(.NMASTER(N), .SRAM_ADDR_W(AW), .CNT_W(CW)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .bus            (bus),
      .cnt_clr_i      (cnt_clr),
      .conflict_cnt_o (cnt)
   );

   // Macro model: masked write, registered read.
   always @(posedge clk) begin
      if (!bus.s_csb_o) begin
         if (!bus.s_web_o) begin
            for (int b = 0; b < 4; b++)
               if (bus.s_wmask_o[b])
                  macro_mem[bus.s_addr_o][8*b +: 8] <= bus.s_din_o[8*b +: 8];
         end else begin
            bus.s_dout_i <= macro_mem[bus.s_addr_o];
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
      end
   endtask

   // Response monitor.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (bus.m_rvalid_o != '0) begin
            if (q.size() == 0) begin
               chk("rvalid_unexpected", 32'(bus.m_rvalid_o), 32'h0);
            end else begin
               rsp_t e;
               e = q.pop_front();
               chk("rvalid", 32'(bus.m_rvalid_o), 32'(1 << e.idx));
               chk("rdata", bus.m_rdata_o, e.data);
               $display("rsp  cyc=%0d master=%0d rdata=%h", cyc, e.idx, bus.m_rdata_o);
            end
         end else begin
            chk("rdata_idle", bus.m_rdata_o, 32'h0);
            if (q.size() > 0 && q[0].cyc < cyc) begin
               chk("rvalid_missing", 32'(bus.m_rvalid_o), 32'(1 << q[0].idx));
               void'(q.pop_front());
            end
         end
      end
   end

   task automatic cycle(input logic [N-1:0] req, input logic [N-1:0] we,
                        input logic [4*N-1:0] be, input logic [AW*N-1:0] addr,
                        input logic [32*N-1:0] wdata, input logic clr,
                        input bit mid_rst = 1'b0);
      int w;
      int j;
      int wa;
      logic [31:0] d;
      @(negedge clk);
      bus.m_req_i   = req;
      bus.m_we_i    = we;
      bus.m_be_i    = be;
      bus.m_addr_i  = addr;
      bus.m_wdata_i = wdata;
      cnt_clr       = clr;
      #3;
      w = -1;
      for (int k = 1; k <= N; k++) begin
         j = (m_last + k) % N;
         if (w < 0 && req[j]) w = j;
      end
      chk("conflict_cnt", 32'(cnt), 32'(m_cnt));
      if (w < 0) begin
         chk("gnt", 32'(bus.m_gnt_o), 32'h0);
         chk("csb", 32'(bus.s_csb_o), 32'h1);
         chk("web", 32'(bus.s_web_o), 32'h1);
         chk("wmask", 32'(bus.s_wmask_o), 32'h0);
         chk("s_addr", 32'(bus.s_addr_o), 32'h0);
         chk("s_din", bus.s_din_o, 32'h0);
         $display("req  cyc=%0d req=%b no grant cnt=%0d", cyc, req, cnt);
      end else begin
         wa = int'(addr[w*AW + 2 +: AW-2]);
         d  = wdata[32*w +: 32];
         chk("gnt", 32'(bus.m_gnt_o), 32'(1 << w));
         chk("csb", 32'(bus.s_csb_o), 32'h0);
         chk("web", 32'(bus.s_web_o), 32'(!we[w]));
         chk("wmask", 32'(bus.s_wmask_o), 32'(be[4*w +: 4]));
         chk("s_addr", 32'(bus.s_addr_o), 32'(wa));
         chk("s_din", bus.s_din_o, d);
         $display("req  cyc=%0d req=%b gnt=M%0d %s word=%h", cyc, req, w, we[w] ? "WR" : "RD", wa);
         if (!mid_rst) begin
            if (we[w]) begin
               for (int b = 0; b < 4; b++)
                  if (be[4*w + b]) exp_mem[wa][8*b +: 8] = d[8*b +: 8];
               q.push_back('{idx: w, data: 32'h0, cyc: cyc});
            end else begin
               q.push_back('{idx: w, data: exp_mem[wa], cyc: cyc});
            end
         end
         m_last = w;
      end
      if (clr) m_cnt = 0;
      else if ($countones(req) >= 2 && m_cnt < (1 << CW) - 1) m_cnt++;
      if (mid_rst) begin
         #1;
         rst_ni = 1'b0;
         q.delete();
         m_last = N - 1;
         m_cnt  = 0;
      end
   endtask

   initial begin
      bus.m_req_i   = '0;
      bus.m_we_i    = '0;
      bus.m_be_i    = '0;
      bus.m_addr_i  = '0;
      bus.m_wdata_i = '0;
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      cycle(2'b00, 2'b00, 8'h00, '0, '0, 1'b0);

      // Both masters contend: alternating grants starting with M0.
      repeat (4) cycle(2'b11, 2'b00, 8'hFF, {11'h020, 11'h010}, '0, 1'b0);

      // Write through M0, read back through M1 at the same word.
      cycle(2'b01, 2'b01, 8'h0F, {11'h000, 11'h010}, {32'h0, 32'hDEADBEEF}, 1'b0);
      cycle(2'b10, 2'b00, 8'hF0, {11'h010, 11'h000}, '0, 1'b0);

      // Single-byte merge over the previous word.
      cycle(2'b01, 2'b01, 8'h04, {11'h000, 11'h010}, {32'h0, 32'h00AA0000}, 1'b0);
      cycle(2'b01, 2'b00, 8'h0F, {11'h000, 11'h010}, '0, 1'b0);

      // Lone requester gets every cycle.
      repeat (5) cycle(2'b10, 2'b00, 8'hF0, {11'h010, 11'h000}, '0, 1'b0);

      // Reset lands between grant and response: response dropped, pointer restored.
      cycle(2'b01, 2'b00, 8'h0F, {11'h000, 11'h010}, '0, 1'b0, 1'b1);
      cycle(2'b00, 2'b00, 8'h00, '0, '0, 1'b0);
      rst_ni = 1'b1;
      cycle(2'b11, 2'b00, 8'hFF, {11'h010, 11'h010}, '0, 1'b0);

      // Counter saturation, then clear while still contended.
      repeat (10) cycle(2'b11, 2'b00, 8'hFF, {11'h010, 11'h010}, '0, 1'b0);
      cycle(2'b11, 2'b00, 8'hFF, {11'h010, 11'h010}, '0, 1'b1);
      cycle(2'b00, 2'b00, 8'h00, '0, '0, 1'b0);

      repeat (300) begin
         cycle(2'($urandom), 2'($urandom), 8'($urandom),
               {5'b0, 6'($urandom), 5'b0, 6'($urandom)},
               {$urandom, $urandom}, ($urandom_range(15) == 0));
      end

      repeat (3) cycle(2'b00, 2'b00, 8'h00, '0, '0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
